// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered decode/forward/issue stage feeding the MIPS ALU
//
// Decodes opcode/funct into the ALU select code and shift amount, resolves operand
// forwarding from EX/MEM and MEM/WB, and presents the result from a pipeline
// register. The register can be held (stall) or squashed (flush).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   valid_in                      decoded instruction present this cycle
//   opcode, funct, shamt_in,      instruction fields
//   imm16
//   rs_addr, rt_addr, rd_addr     register specifiers
//   rs_data, rt_data              register-file read data
//   stall, flush                  hold / squash the issue register (flush wins)
//   exmem_wr_en/rd/result         EX/MEM forwarding source (highest priority)
//   memwb_wr_en/rd/result         MEM/WB forwarding source
//   valid_out                     issue register holds a live instruction
//   input1, input2                ALU operands
//   selectionLines, shamt         ALU operation select and shift amount
//   dest_reg, reg_write           write-back register and enable
//   illegal                       unrecognised opcode/funct
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt_in,
    input  logic [15:0] imm16,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        exmem_wr_en,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_wr_en,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        valid_out,
    output logic [31:0] input1,
    output logic [31:0] input2,
    output logic [3:0]  selectionLines,
    output logic [4:0]  shamt,
    output logic [4:0]  dest_reg,
    output logic        reg_write,
    output logic        illegal
);

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_SLL = 4'b1000;
    localparam logic [3:0] SEL_SRL = 4'b1001;
    localparam logic [3:0] SEL_SLTU = 4'b1011;

    logic [31:0] fwd_rs, fwd_rt;
    logic [31:0] sext_imm, zext_imm;

    logic        valid_q, valid_d;
    logic [31:0] in1_q, in1_d;
    logic [31:0] in2_q, in2_d;
    logic [3:0]  sel_q, sel_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [4:0]  dest_q, dest_d;
    logic        rw_q, rw_d;
    logic        ill_q, ill_d;
    logic        writes;
    logic        bad;

    // Register $0 is never forwarded: a producer targeting $0 writes nothing.
    always_comb begin
        fwd_rs = rs_data;
        if (exmem_wr_en && exmem_rd != 5'd0 && exmem_rd == rs_addr)
            fwd_rs = exmem_result;
        else if (memwb_wr_en && memwb_rd != 5'd0 && memwb_rd == rs_addr)
            fwd_rs = memwb_result;

        fwd_rt = rt_data;
        if (exmem_wr_en && exmem_rd != 5'd0 && exmem_rd == rt_addr)
            fwd_rt = exmem_result;
        else if (memwb_wr_en && memwb_rd != 5'd0 && memwb_rd == rt_addr)
            fwd_rt = memwb_result;
    end

    assign sext_imm = {{16{imm16[15]}}, imm16};
    assign zext_imm = {16'h0000, imm16};

    always_comb begin
        sel_d   = SEL_ADD;
        shamt_d = 5'd0;
        dest_d  = rt_addr;
        in1_d   = fwd_rs;
        in2_d   = fwd_rt;
        writes  = 1'b1;
        bad     = 1'b0;
        case (opcode)
            6'h00: begin
                dest_d = rd_addr;
                case (funct)
                    6'h20, 6'h21: sel_d = SEL_ADD;
                    6'h22, 6'h23: sel_d = SEL_SUB;
                    6'h24:        sel_d = SEL_AND;
                    6'h25:        sel_d = SEL_OR;
                    6'h2A:        sel_d = SEL_SLT;
                    6'h2B:        sel_d = SEL_SLTU;
                    6'h00: begin sel_d = SEL_SLL; shamt_d = shamt_in; end
                    6'h02: begin sel_d = SEL_SRL; shamt_d = shamt_in; end
                    default:      bad = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h23: in2_d = sext_imm;
            6'h0A: begin sel_d = SEL_SLT;  in2_d = sext_imm; end
            6'h0B: begin sel_d = SEL_SLTU; in2_d = sext_imm; end
            6'h0C: begin sel_d = SEL_AND;  in2_d = zext_imm; end
            6'h0D: begin sel_d = SEL_OR;   in2_d = zext_imm; end
            6'h2B: begin in2_d = sext_imm; writes = 1'b0; end
            6'h04: begin sel_d = SEL_SUB;  writes = 1'b0; end
            default: bad = 1'b1;
        endcase
        // An illegal instruction falls back to ADD select; operands stay forwarded.
        if (bad)
            sel_d = SEL_ADD;
        valid_d = valid_in;
        ill_d   = valid_in & bad;
        // Writing $0 is suppressed so that sll $0,$0,0 becomes a true NOP.
        rw_d    = valid_in & writes & ~bad & (dest_d != 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            in1_q   <= 32'd0;
            in2_q   <= 32'd0;
            sel_q   <= 4'd0;
            shamt_q <= 5'd0;
            dest_q  <= 5'd0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (flush) begin
            // Data fields are left as they were; only the control bits are killed.
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (!stall) begin
            valid_q <= valid_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            sel_q   <= sel_d;
            shamt_q <= shamt_d;
            dest_q  <= dest_d;
            rw_q    <= rw_d;
            ill_q   <= ill_d;
        end
    end

    assign valid_out      = valid_q;
    assign input1         = in1_q;
    assign input2         = in2_q;
    assign selectionLines = sel_q;
    assign shamt          = shamt_q;
    assign dest_reg       = dest_q;
    assign reg_write      = rw_q;
    assign illegal        = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt_in;
    logic [15:0] imm16;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_data, rt_data;
    logic        stall, flush;
    logic        exmem_wr_en, memwb_wr_en;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        valid_out, reg_write, illegal;
    logic [31:0] input1, input2;
    logic [3:0]  selectionLines;
    logic [4:0]  shamt, dest_reg;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .opcode(opcode), .funct(funct), .shamt_in(shamt_in), .imm16(imm16),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .stall(stall), .flush(flush),
        .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .valid_out(valid_out), .input1(input1), .input2(input2),
        .selectionLines(selectionLines), .shamt(shamt), .dest_reg(dest_reg),
        .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd;
        logic        exen;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        mwen;
        logic [4:0]  mwrd;
        logic [31:0] mwres;
        logic [3:0]  e_sel;
        logic [31:0] e_in1, e_in2;
        logic [4:0]  e_sh, e_dest;
        logic        e_rw, e_ill;
        logic        chk_ops;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        opcode = v.op;  funct = v.fn;  shamt_in = v.sh;  imm16 = v.imm;
        rs_addr = v.rs; rt_addr = v.rt; rd_addr = v.rd;
        rs_data = v.rsd; rt_data = v.rtd;
        exmem_wr_en = v.exen; exmem_rd = v.exrd; exmem_result = v.exres;
        memwb_wr_en = v.mwen; memwb_rd = v.mwrd; memwb_result = v.mwres;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, " valid_out"}, 32'(valid_out), 32'd1);
        check({tag, " selectionLines"}, 32'(selectionLines), 32'(v.e_sel));
        check({tag, " shamt"}, 32'(shamt), 32'(v.e_sh));
        check({tag, " dest_reg"}, 32'(dest_reg), 32'(v.e_dest));
        check({tag, " reg_write"}, 32'(reg_write), 32'(v.e_rw));
        check({tag, " illegal"}, 32'(illegal), 32'(v.e_ill));
        if (v.chk_ops) begin
            check({tag, " input1"}, input1, v.e_in1);
            check({tag, " input2"}, input2, v.e_in2);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid_out"}, 32'(valid_out), 32'd0);
        check({tag, " input1"}, input1, 32'd0);
        check({tag, " input2"}, input2, 32'd0);
        check({tag, " selectionLines"}, 32'(selectionLines), 32'd0);
        check({tag, " shamt"}, 32'(shamt), 32'd0);
        check({tag, " dest_reg"}, 32'(dest_reg), 32'd0);
        check({tag, " reg_write"}, 32'(reg_write), 32'd0);
        check({tag, " illegal"}, 32'(illegal), 32'd0);
    endtask

    initial begin
        //          op     fn     sh  imm       rs rt rd rsd       rtd       exen exrd exres  mwen mwrd mwres  sel      in1       in2           sh dst rw ill chk
        vecs[0]  = '{6'h00, 6'h20, 0, 16'h0000, 1, 2, 3, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b0010, 32'd5,    32'd7,        0, 3,  1, 0, 1}; // add
        vecs[1]  = '{6'h08, 6'h00, 0, 16'hFFF0, 1, 5, 0, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b0010, 32'd5,    32'hFFFFFFF0, 0, 5,  1, 0, 1}; // addi
        vecs[2]  = '{6'h0C, 6'h00, 0, 16'hFFF0, 1, 5, 0, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b0000, 32'd5,    32'h0000FFF0, 0, 5,  1, 0, 1}; // andi
        vecs[3]  = '{6'h00, 6'h20, 0, 16'h0000, 4, 2, 3, 32'h11,   32'd7,    1, 4, 32'hAA, 1, 4, 32'hBB, 4'b0010, 32'hAA,   32'd7,        0, 3,  1, 0, 1}; // EX/MEM wins
        vecs[4]  = '{6'h00, 6'h20, 0, 16'h0000, 4, 2, 3, 32'h11,   32'd7,    1, 0, 32'hAA, 1, 4, 32'hBB, 4'b0010, 32'hBB,   32'd7,        0, 3,  1, 0, 1}; // exmem_rd=0
        vecs[5]  = '{6'h00, 6'h00, 0, 16'h0000, 0, 0, 0, 32'd0,    32'd0,    0, 0, 0,      0, 0, 0,      4'b1000, 32'd0,    32'd0,        0, 0,  0, 0, 1}; // sll NOP
        vecs[6]  = '{6'h00, 6'h02, 5, 16'h0000, 0, 2, 6, 32'd0,    32'd7,    0, 0, 0,      0, 0, 0,      4'b1001, 32'd0,    32'd7,        5, 6,  1, 0, 1}; // srl
        vecs[7]  = '{6'h04, 6'h00, 0, 16'h0010, 1, 2, 0, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b0110, 32'd5,    32'd7,        0, 2,  0, 0, 1}; // beq
        vecs[8]  = '{6'h2B, 6'h00, 0, 16'h8004, 1, 2, 0, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b0010, 32'd5,    32'hFFFF8004, 0, 2,  0, 0, 1}; // sw
        vecs[9]  = '{6'h0A, 6'h00, 0, 16'h7FFF, 1, 2, 0, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b0111, 32'd5,    32'h00007FFF, 0, 2,  1, 0, 1}; // slti
        vecs[10] = '{6'h0D, 6'h00, 0, 16'h8000, 1, 2, 0, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b0001, 32'd5,    32'h00008000, 0, 2,  1, 0, 1}; // ori
        vecs[11] = '{6'h00, 6'h2B, 3, 16'h0000, 1, 2, 9, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b1011, 32'd5,    32'd7,        0, 9,  1, 0, 1}; // sltu, shamt ignored
        vecs[12] = '{6'h00, 6'h22, 0, 16'h0000, 1, 2, 9, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b0110, 32'd5,    32'd7,        0, 9,  1, 0, 1}; // sub
        vecs[13] = '{6'h3F, 6'h00, 0, 16'h0000, 1, 2, 3, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b0010, 32'd0,    32'd0,        0, 2,  0, 1, 0}; // illegal opcode
        vecs[14] = '{6'h00, 6'h3F, 0, 16'h0000, 1, 2, 3, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b0010, 32'd0,    32'd0,        0, 3,  0, 1, 0}; // illegal funct
        vecs[15] = '{6'h00, 6'h25, 0, 16'h0000, 1, 2, 3, 32'd5,    32'd7,    1, 7, 32'hCC, 1, 2, 32'hDD, 4'b0001, 32'd5,    32'hDD,       0, 3,  1, 0, 1}; // or, rt from MEM/WB
        vecs[16] = '{6'h23, 6'h00, 0, 16'hFFFC, 1, 2, 0, 32'd5,    32'd7,    0, 1, 32'hEE, 0, 0, 0,      4'b0010, 32'd5,    32'hFFFFFFFC, 0, 2,  1, 0, 1}; // lw, ex disabled
        vecs[17] = '{6'h00, 6'h24, 0, 16'h0000, 1, 2, 0, 32'd5,    32'd7,    0, 0, 0,      0, 0, 0,      4'b0000, 32'd5,    32'd7,        0, 0,  0, 0, 1}; // and to $0

        rst = 1'b1; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(vecs[0]);
        #2;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            valid_in = 1'b1;
            @(posedge clk);
            #1;
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Bubble: valid_in low clears valid/reg_write/illegal.
        @(negedge clk);
        drive(vecs[13]);
        valid_in = 1'b0;
        @(posedge clk); #1;
        check("bubble valid_out", 32'(valid_out), 32'd0);
        check("bubble reg_write", 32'(reg_write), 32'd0);
        check("bubble illegal", 32'(illegal), 32'd0);

        // Stall for 3 cycles with changing inputs and forwarding sources.
        @(negedge clk);
        drive(vecs[0]);
        valid_in = 1'b1;
        @(posedge clk); #1;
        check_vec("preload", vecs[0]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(vecs[1 + k]);
            exmem_wr_en = 1'b1; exmem_rd = 5'd1; exmem_result = 32'h1234 + k;
            memwb_wr_en = 1'b1; memwb_rd = 5'd2; memwb_result = 32'h5678 + k;
            stall = 1'b1;
            @(posedge clk); #1;
            check_vec($sformatf("stall%0d", k), vecs[0]);
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        check("stallflush valid_out", 32'(valid_out), 32'd0);
        check("stallflush reg_write", 32'(reg_write), 32'd0);
        check("stallflush illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        drive(vecs[2]);
        @(posedge clk); #1;
        check_vec("postflush", vecs[2]);

        // Illegal, then async reset mid-stall between edges.
        @(negedge clk);
        drive(vecs[13]);
        @(posedge clk); #1;
        check_vec("illegal_pre_rst", vecs[13]);
        @(negedge clk);
        stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        stall = 1'b0;
        drive(vecs[0]);
        rst = 1'b0;
        #1;
        check("rst_release valid_out", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        check_vec("first_load", vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
